// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one 4b+4b->5b adder among N_REQ requesters.
// Optional saturating overflow counter on port ovf_count when ADDARB_OVF_CNT_EN is defined.
module adder_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [4*N_REQ-1:0] req_a,
  input  logic [4*N_REQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [4:0]         rsp_sum,
  output logic [ID_W-1:0]    rsp_id,
  output logic               busy
`ifdef ADDARB_OVF_CNT_EN
  ,
  output logic [15:0]        ovf_count
`endif
);

  // state  | meaning
  // S_IDLE | searching for a requester, grant issued combinationally
  // S_EXEC | latched operands drive the adder for one cycle
  // S_RESP | response held until rsp_ready
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic [3:0]      a_q, a_d;
  logic [3:0]      b_q, b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [4:0]      rsp_sum_q, rsp_sum_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [4:0]      sum_next;
  logic            gnt_found;
  int              gnt_int;
  logic            handshake;

  // Search from rr_ptr upward, wrapping modulo N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_int   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_found && req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
        gnt_found = 1'b1;
        gnt_int   = (int'(rr_ptr_q) + k) % N_REQ;
      end
    end
  end

  // Reset forces req_ready low even though it is combinational.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == S_IDLE && gnt_found) begin
      req_ready[gnt_int] = 1'b1;
    end
  end

  assign handshake = |(req_valid & req_ready);
  assign sum_next  = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          a_d      = req_a[4*gnt_int +: 4];
          b_d      = req_b[4*gnt_int +: 4];
          gnt_id_d = ID_W'(gnt_int);
          rr_ptr_d = ID_W'((gnt_int + 1) % N_REQ);
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_sum_d   = sum_next;
        rsp_id_d    = gnt_id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q == S_EXEC) || (state_q == S_RESP);

`ifdef ADDARB_OVF_CNT_EN
  logic [15:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_EXEC && sum_next[4] && ovf_q != 16'hFFFF) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_count = ovf_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: vector table, hand sequences,
// and randomized operations against a transaction-level round-robin model.
module tb_adder_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_sum;
  logic [1:0]  rsp_id;
  logic        busy;
`ifdef ADDARB_OVF_CNT_EN
  logic [15:0] ovf_count;
  int          exp_ovf = 0;
`endif

  int checks   = 0;
  int failures = 0;
  int rr_model = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.N_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef ADDARB_OVF_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  typedef struct {
    logic [3:0]  vmask;
    logic [15:0] a;
    logic [15:0] b;
    int          hold;
    int          exp_id;
    int          exp_sum;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input int ptr, input logic [3:0] m);
    for (int k = 0; k < 4; k++) begin
      if (m[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic int lane_sum(input logic [15:0] a, input logic [15:0] b, input int g);
    return int'((a >> (4 * g)) & 16'hF) + int'((b >> (4 * g)) & 16'hF);
  endfunction

  // One complete operation: grant, EXEC, RESP held for 'hold' cycles, then released.
  task automatic run_op(input logic [3:0] vmask, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input int exp_g, input int exp_s);
    req_valid = vmask; req_a = a; req_b = b; rsp_ready = 1'b0;
    #1;
    chk("grant_onehot", 32'(req_ready), 32'(4'b0001 << exp_g));
    tick();
    req_valid = 4'b0000;
    #1;
    chk("exec_ready0", 32'(req_ready), 0);
    chk("exec_busy", 32'(busy), 1);
    chk("exec_rspv0", 32'(rsp_valid), 0);
    tick();
    chk("resp_valid", 32'(rsp_valid), 1);
    chk("resp_sum", 32'(rsp_sum), 32'(exp_s));
    chk("resp_id", 32'(rsp_id), 32'(exp_g));
`ifdef ADDARB_OVF_CNT_EN
    if (exp_s >= 16 && exp_ovf < 65535) exp_ovf++;
    chk("ovf_count", 32'(ovf_count), 32'(exp_ovf));
`endif
    req_valid = 4'b1111;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_sum", 32'(rsp_sum), 32'(exp_s));
      chk("hold_id", 32'(rsp_id), 32'(exp_g));
      chk("hold_ready0", 32'(req_ready), 0);
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("done_rspv0", 32'(rsp_valid), 0);
    chk("done_busy0", 32'(busy), 0);
    rr_model = (exp_g + 1) % 4;
  endtask

  initial begin
    vecs[0] = '{4'b0010, 16'h0090, 16'h0070, 0, 1, 16};
    vecs[1] = '{4'b1111, 16'h0F00, 16'h0F00, 5, 2, 30};
    vecs[2] = '{4'b0011, 16'h0000, 16'h0000, 1, 0, 0};
    vecs[3] = '{4'b1001, 16'h8000, 16'h8000, 0, 3, 16};
    vecs[4] = '{4'b0001, 16'h000F, 16'h0001, 2, 0, 16};
    vecs[5] = '{4'b1000, 16'h7000, 16'h5000, 0, 3, 12};

    rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rspv", 32'(rsp_valid), 0);
    chk("rst_sum", 32'(rsp_sum), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_busy", 32'(busy), 0);
`ifdef ADDARB_OVF_CNT_EN
    chk("rst_ovf", 32'(ovf_count), 0);
`endif
    req_valid = 4'b0000;
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].vmask, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].exp_id, vecs[i].exp_sum);
    end

    // Requester withdraws before the handshake edge: no grant, pointer unchanged.
    req_valid = 4'b0100;
    #1;
    chk("drop_ready", 32'(req_ready), 32'(4'b0100));
    req_valid = 4'b0000;
    tick();
    chk("drop_busy0", 32'(busy), 0);
    chk("drop_ready0", 32'(req_ready), 0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0]  m;
      logic [15:0] a, b;
      int g;
      m = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      b = 16'($urandom);
      if (m == 4'b0000) begin
        req_valid = m;
        #1;
        chk("idle_ready0", 32'(req_ready), 0);
        tick();
        chk("idle_busy0", 32'(busy), 0);
      end else begin
        g = rr_pick(rr_model, m);
        run_op(m, a, b, int'($urandom_range(0, 3)), g, lane_sum(a, b, g));
      end
    end

    // Reset during EXEC drops the operation and restarts the pointer.
    req_valid = 4'b0100; req_a = 16'h0300; req_b = 16'h0400;
    #1;
    chk("r6_ready", 32'(req_ready), 32'(4'b0100));
    tick();
    chk("r6_exec_busy", 32'(busy), 1);
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("r6_rst_ready", 32'(req_ready), 0);
    chk("r6_rst_busy", 32'(busy), 0);
    chk("r6_rst_rspv", 32'(rsp_valid), 0);
    tick();
    req_valid = 4'b0000;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("r6_no_rsp", 32'(rsp_valid), 0);
    end
    rr_model = 0;

    // All requesters held with rsp_ready=1: grants 0,1,2,3,0 every third cycle.
    req_valid = 4'b1111; rsp_ready = 1'b1; req_a = 16'h1234; req_b = 16'h4321;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (c % 3 == 0) chk("rr_grant", 32'(req_ready), 32'(4'b0001 << ((c / 3) % 4)));
      else            chk("rr_gap", 32'(req_ready), 0);
      if (c % 3 == 2) chk("rr_rsp_sum", 32'(rsp_sum), 5);
      @(posedge clk);
    end
    #1;
    req_valid = 4'b0000; rsp_ready = 1'b0;
    rr_model = 1;
    run_op(4'b1111, 16'hFFFF, 16'hFFFF, 0, 1, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
